// File: rtl/hm01b0_pattern_gen.sv
// hm01b0_pattern_gen: synthetic HM01B0-style camera source with programmable frame geometry and test patterns.
`timescale 1ns/1ps
module hm01b0_pattern_gen #(
    parameter int WIDTH           = 320,
    parameter int HEIGHT          = 240,
    parameter int HBLANK          = 10,
    parameter int VBLANK          = 2,
    parameter int BYTES_PER_PIXEL = 1,
    parameter int FRAME_CNT_W     = 16
) (
    input  logic                   mclk,
    input  logic                   nreset,
    input  logic                   enable,
    input  logic                   single_shot,
    input  logic                   trigger,
    input  logic [1:0]             pattern_sel,
    output logic                   pclk,
    output logic [7:0]             pixdata,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   busy
);
    localparam int ACT         = WIDTH * BYTES_PER_PIXEL;
    localparam int LINE_LEN    = ACT + HBLANK;
    localparam int FRAME_LINES = HEIGHT + VBLANK;
    localparam int BXW         = $clog2(LINE_LEN);
    localparam int LYW         = $clog2(FRAME_LINES);
    localparam logic [BXW-1:0] BX_LAST = BXW'(LINE_LEN - 1);
    localparam logic [BXW-1:0] BX_ACT  = BXW'(ACT);
    localparam logic [LYW-1:0] LY_LAST = LYW'(FRAME_LINES - 1);
    localparam logic [LYW-1:0] LY_ACT  = LYW'(HEIGHT);

    if (BYTES_PER_PIXEL != 1 && BYTES_PER_PIXEL != 2) begin : g_bpp_check
        $error("BYTES_PER_PIXEL must be 1 or 2");
    end

    typedef enum logic {IDLE, FRAME} state_t;

    state_t                 state, nstate;
    logic [BXW-1:0]         bx, nbx, pxb;
    logic [LYW-1:0]         ly, nly;
    logic [1:0]             psel, npsel;
    logic [FRAME_CNT_W-1:0] nfc;
    logic [7:0]             px, py, v, npix;
    logic                   start, fend, nvs, nhs, nfd;

    assign pclk  = mclk;
    assign busy  = state == FRAME;
    assign start = single_shot ? trigger : enable;
    assign fend  = state == FRAME && bx == BX_LAST && ly == LY_LAST;

    always_comb begin
        nstate = state;
        nbx    = bx;
        nly    = ly;
        npsel  = psel;
        nfc    = frame_count;
        if (state == IDLE) begin
            if (start) begin
                nstate = FRAME;
                nbx    = '0;
                nly    = '0;
                npsel  = pattern_sel;
            end
        end else if (fend) begin
            nfc    = frame_count + 1'b1;
            nbx    = '0;
            nly    = '0;
            npsel  = pattern_sel;
            nstate = (!single_shot && enable) ? FRAME : IDLE;
        end else if (bx == BX_LAST) begin
            nbx = '0;
            nly = ly + 1'b1;
        end else begin
            nbx = bx + 1'b1;
        end
    end

    // Outputs are computed from the position being loaded so they line up with it.
    always_comb begin
        nvs  = nstate == FRAME && nly < LY_ACT;
        nhs  = nvs && nbx < BX_ACT;
        nfd  = nstate == FRAME && nbx == BX_LAST && nly == LY_LAST;
        pxb  = (BYTES_PER_PIXEL == 2) ? (nbx >> 1) : nbx;
        px   = 8'(pxb);
        py   = 8'(nly);
        v    = npsel == 2'd0 ? px + py :
               npsel == 2'd1 ? {8{px[3] ^ py[3]}} :
               npsel == 2'd2 ? 8'(nfc) : px;
        npix = !nhs ? 8'h00 : (BYTES_PER_PIXEL == 2 && nbx[0]) ? ~v : v;
    end

    always_ff @(posedge mclk or negedge nreset) begin
        if (!nreset) begin
            state       <= IDLE;
            bx          <= '0;
            ly          <= '0;
            psel        <= '0;
            frame_count <= '0;
            pixdata     <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state       <= nstate;
            bx          <= nbx;
            ly          <= nly;
            psel        <= npsel;
            frame_count <= nfc;
            pixdata     <= npix;
            hsync       <= nhs;
            vsync       <= nvs;
            frame_done  <= nfd;
        end
    end
endmodule

// File: tb/tb_hm01b0_pattern_gen.sv
// tb_hm01b0_pattern_gen: scoreboard and table checks of the pattern generator in 1- and 2-byte-per-pixel builds.
`timescale 1ns/1ps
module tb_hm01b0_pattern_gen;
    logic        mclk = 1'b0, nreset = 1'b0, enable = 1'b0, single_shot = 1'b0, trigger = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        pclk, hsync, vsync, frame_done, busy;
    logic [7:0]  pixdata;
    logic [15:0] frame_count;
    logic        enable_b = 1'b0;
    logic        pclk_b, hsync_b, vsync_b, frame_done_b, busy_b;
    logic [7:0]  pixdata_b;
    logic [15:0] frame_count_b;

    hm01b0_pattern_gen #(.WIDTH(4), .HEIGHT(3), .HBLANK(2), .VBLANK(1), .BYTES_PER_PIXEL(1), .FRAME_CNT_W(16)) u_dut (
        .mclk(mclk), .nreset(nreset), .enable(enable), .single_shot(single_shot), .trigger(trigger),
        .pattern_sel(pattern_sel), .pclk(pclk), .pixdata(pixdata), .hsync(hsync), .vsync(vsync),
        .frame_done(frame_done), .frame_count(frame_count), .busy(busy));

    hm01b0_pattern_gen #(.WIDTH(2), .HEIGHT(2), .HBLANK(2), .VBLANK(1), .BYTES_PER_PIXEL(2), .FRAME_CNT_W(16)) u_dut_b (
        .mclk(mclk), .nreset(nreset), .enable(enable_b), .single_shot(1'b0), .trigger(1'b0),
        .pattern_sel(2'd3), .pclk(pclk_b), .pixdata(pixdata_b), .hsync(hsync_b), .vsync(vsync_b),
        .frame_done(frame_done_b), .frame_count(frame_count_b), .busy(busy_b));

    always #5 mclk = ~mclk;

    typedef struct {
        logic [7:0]  pix;
        logic        hs, vs, fd;
        logic [15:0] fc;
        int          bx, ly;
        logic [1:0]  psel;
    } rec_t;

    typedef struct {
        logic [1:0] psel;
        int         ly, bx;
        logic [7:0] exp;
    } vec_t;

    rec_t       sb[$];
    rec_t       mr;
    logic [7:0] cap [4][4][6];
    logic [7:0] cap_b [3][6];
    int         cnt_b = 0, hs_cnt_b = 0, vs_cnt_b = 0;
    int         n_pass = 0, n_chk = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [7:0] pat(input logic [1:0] ps, input int x, input int y, input logic [15:0] fc);
        case (ps)
            2'd0:    return 8'(x + y);
            2'd1:    return (((x >> 3) ^ (y >> 3)) & 1) != 0 ? 8'hFF : 8'h00;
            2'd2:    return fc[7:0];
            default: return 8'(x);
        endcase
    endfunction

    task automatic push_frame(input logic [1:0] ps, input logic [15:0] fc);
        rec_t r;
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 6; x++) begin
                r.hs   = y < 3 && x < 4;
                r.vs   = y < 3;
                r.pix  = r.hs ? pat(ps, x, y, fc) : 8'h00;
                r.fd   = x == 5 && y == 3;
                r.fc   = fc;
                r.bx   = x;
                r.ly   = y;
                r.psel = ps;
                sb.push_back(r);
            end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    always @(negedge mclk) begin
        if (nreset) begin
            if (busy) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mr = sb.pop_front();
                    chk($sformatf("frame psel%0d fc%0d y%0d x%0d {pix,hs,vs,fd,fc}", mr.psel, mr.fc, mr.ly, mr.bx),
                        {5'd0, pixdata, hsync, vsync, frame_done, frame_count},
                        {5'd0, mr.pix, mr.hs, mr.vs, mr.fd, mr.fc});
                    cap[mr.psel][mr.ly][mr.bx] = pixdata;
                end
            end else begin
                chk("idle_outputs_zero", {21'd0, pixdata, hsync, vsync, frame_done}, 32'd0);
            end
            if (busy_b && cnt_b < 18) begin
                cap_b[cnt_b / 6][cnt_b % 6] = pixdata_b;
                hs_cnt_b += int'(hsync_b);
                vs_cnt_b += int'(vsync_b);
                cnt_b++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tv [16];
        logic [7:0] row_b [6];
        tv = '{
            '{2'd3, 0, 0, 8'h00}, '{2'd3, 0, 1, 8'h01}, '{2'd3, 0, 2, 8'h02}, '{2'd3, 0, 3, 8'h03},
            '{2'd3, 0, 4, 8'h00}, '{2'd3, 0, 5, 8'h00},
            '{2'd0, 2, 0, 8'h02}, '{2'd0, 2, 1, 8'h03}, '{2'd0, 2, 2, 8'h04}, '{2'd0, 2, 3, 8'h05},
            '{2'd0, 2, 4, 8'h00}, '{2'd0, 3, 0, 8'h00},
            '{2'd1, 1, 2, 8'h00}, '{2'd1, 3, 1, 8'h00},
            '{2'd2, 0, 0, 8'h09}, '{2'd2, 2, 3, 8'h09}
        };
        row_b = '{8'h00, 8'hFF, 8'h01, 8'hFE, 8'h00, 8'h00};
        for (int p = 0; p < 4; p++)
            for (int y = 0; y < 4; y++)
                for (int x = 0; x < 6; x++) cap[p][y][x] = 8'hAA;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 6; x++) cap_b[y][x] = 8'hAA;

        #2;
        chk("reset {pix,hs,vs,fd,busy}", {23'd0, pixdata, hsync, vsync, frame_done, busy}, 32'd0);
        chk("reset frame_count", 32'(frame_count), 32'd0);
        @(posedge mclk);
        #1 nreset = 1'b1;
        tick(2);

        enable_b = 1'b1;
        tick(1);
        enable_b = 1'b0;
        tick(20);
        chk("bpp2 busy after frame", 32'(busy_b), 32'd0);
        chk("bpp2 frame_count", 32'(frame_count_b), 32'd1);
        chk("bpp2 hsync cycles", 32'(hs_cnt_b), 32'd8);
        chk("bpp2 vsync cycles", 32'(vs_cnt_b), 32'd12);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 6; x++)
                chk($sformatf("bpp2 byte y%0d x%0d", y, x), 32'(cap_b[y][x]), y < 2 ? 32'(row_b[x]) : 32'd0);

        pattern_sel = 2'd3;
        push_frame(2'd3, 16'd0);
        push_frame(2'd3, 16'd1);
        enable = 1'b1;
        tick(25);
        enable = 1'b0;
        tick(30);
        chk("freerun frame_count", 32'(frame_count), 32'd2);
        chk("freerun busy", 32'(busy), 32'd0);

        pattern_sel = 2'd0;
        push_frame(2'd0, 16'd2);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(26);

        pattern_sel = 2'd1;
        push_frame(2'd1, 16'd3);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(26);

        single_shot = 1'b1;
        enable = 1'b1;
        tick(5);
        chk("single_shot ignores enable", 32'(busy), 32'd0);
        enable = 1'b0;
        pattern_sel = 2'd3;
        push_frame(2'd3, 16'd4);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(5);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(10);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        tick(15);
        chk("single_shot busy", 32'(busy), 32'd0);
        chk("single_shot frame_count", 32'(frame_count), 32'd5);
        push_frame(2'd3, 16'd5);
        trigger = 1'b1;
        tick(1);
        trigger = 1'b0;
        chk("trigger first {busy,vs,hs,pix}", {21'd0, busy, vsync, hsync, pixdata}, {21'd0, 3'b111, 8'h00});
        tick(26);
        single_shot = 1'b0;

        pattern_sel = 2'd3;
        push_frame(2'd3, 16'd6);
        enable = 1'b1;
        tick(5);
        enable = 1'b0;
        pattern_sel = 2'd0;
        tick(22);
        chk("enable drop busy", 32'(busy), 32'd0);
        chk("enable drop frame_count", 32'(frame_count), 32'd7);
        push_frame(2'd0, 16'd7);
        enable = 1'b1;
        tick(1);
        enable = 1'b0;
        tick(26);

        pattern_sel = 2'd2;
        push_frame(2'd2, 16'd8);
        push_frame(2'd2, 16'd9);
        enable = 1'b1;
        tick(25);
        enable = 1'b0;
        tick(30);
        chk("pattern2 frame_count", 32'(frame_count), 32'd10);
        chk("scoreboard drained", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 16; i++)
            chk($sformatf("table psel%0d y%0d x%0d", tv[i].psel, tv[i].ly, tv[i].bx),
                32'(cap[tv[i].psel][tv[i].ly][tv[i].bx]), 32'(tv[i].exp));

        pattern_sel = 2'd3;
        push_frame(2'd3, 16'd10);
        push_frame(2'd3, 16'd11);
        enable = 1'b1;
        tick(8);
        #2 nreset = 1'b0;
        #1;
        chk("async reset {pix,hs,vs,fd,busy}", {23'd0, pixdata, hsync, vsync, frame_done, busy}, 32'd0);
        chk("async reset frame_count", 32'(frame_count), 32'd0);
        sb.delete();
        push_frame(2'd3, 16'd0);
        #2 nreset = 1'b1;
        tick(1);
        chk("restart {busy,vs,hs,pix}", {21'd0, busy, vsync, hsync, pixdata}, {21'd0, 3'b111, 8'h00});
        enable = 1'b0;
        tick(25);
        chk("restart frame_count", 32'(frame_count), 32'd1);
        chk("restart busy", 32'(busy), 32'd0);
        chk("restart scoreboard drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
